// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the Wishbone load/store data port.
// Also intended for reuse by the instruction-side fetch port.
package lsu_pkg;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_D = 2'd3;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUS  = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   function automatic logic [7:0] size_mask(input logic [1:0] size);
      logic [7:0] m;
      case (size)
         SZ_B:    m = 8'h01;
         SZ_H:    m = 8'h03;
         SZ_W:    m = 8'h0F;
         default: m = 8'hFF;
      endcase
      return m;
   endfunction

   // A dword access only exists on a 64-bit bus.
   function automatic logic misaligned(input logic [1:0] size, input logic [2:0] addr,
                                       input int unsigned dw);
      logic bad;
      case (size)
         SZ_B:    bad = 1'b0;
         SZ_H:    bad = addr[0];
         SZ_W:    bad = (addr[1:0] != 2'b00);
         default: bad = (addr != 3'b000) || (dw != 32'd64);
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Right-justifies a sub-word load from a bus word and sign/zero extends it.
module lsu_load_align
   import lsu_pkg::*;
#(
   parameter  int DW = 32,
   localparam int OW = $clog2(DW / 8)
) (
   input  logic [DW-1:0] i_data,
   input  logic [OW-1:0] i_off,
   input  logic [1:0]    i_size,
   input  logic          i_unsigned,
   output logic [DW-1:0] o_data
);

   logic [DW-1:0] w_shift;
   logic [DW-1:0] w_keep;
   logic          w_sign;

   assign w_shift = i_data >> {i_off, 3'b000};

   always_comb begin
      w_keep = '1;
      w_sign = w_shift[DW-1];
      case (i_size)
         SZ_B: begin w_keep = DW'(8'hFF);         w_sign = w_shift[7];  end
         SZ_H: begin w_keep = DW'(16'hFFFF);      w_sign = w_shift[15]; end
         SZ_W: begin w_keep = DW'(32'hFFFF_FFFF); w_sign = w_shift[31]; end
         default: ;
      endcase
      o_data = (w_shift & w_keep) | (~w_keep & {DW{w_sign & ~i_unsigned}});
   end

endmodule

// File: rtl/wb_data_port_lsu.sv
// Load/store data port: one request at a time onto a Wishbone classic bus,
// with byte-lane steering, misalignment trap, bus timeout and registered response.
module wb_data_port_lsu
   import lsu_pkg::*;
#(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 64,
   parameter int TW      = 7
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_we,
   input  logic [1:0]      req_size,
   input  logic            req_unsigned,
   input  logic [AW-1:0]   req_addr,
   input  logic [DW-1:0]   req_wdata,
   output logic            rsp_valid,
   output logic [DW-1:0]   rsp_rdata,
   output logic            rsp_err,
   output logic            rsp_misaligned,
   output logic            rsp_timeout,
   output logic            busy,
   input  logic [DW-1:0]   dat_i,
   input  logic            ack_i,
   input  logic            err_i,
   output logic [AW-1:0]   adr_o,
   output logic [DW-1:0]   dat_o,
   output logic [DW/8-1:0] sel_o,
   output logic            cyc_o,
   output logic            stb_o,
   output logic            we_o
);

   localparam int SW = DW / 8;
   localparam int OW = $clog2(SW);
   localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   logic [1:0]    r_state;
   logic [OW-1:0] r_off;
   logic [1:0]    r_size;
   logic          r_uns;
   logic          r_lwe;
   logic [TW-1:0] r_cnt;

   logic [OW-1:0] w_off;
   logic          w_mis;
   logic [SW-1:0] w_sel;
   logic [DW-1:0] w_dat;
   logic [DW-1:0] w_load;

   assign w_off = req_addr[OW-1:0];
   assign w_mis = misaligned(req_size, req_addr[2:0], DW);
   assign w_sel = SW'(size_mask(req_size)) << w_off;

   always_comb begin
      case (req_size)
         SZ_B:    w_dat = {SW{req_wdata[7:0]}};
         SZ_H:    w_dat = {(DW/16){req_wdata[15:0]}};
         SZ_W:    w_dat = {(DW/32){req_wdata[31:0]}};
         default: w_dat = req_wdata;
      endcase
   end

   lsu_load_align #(.DW(DW)) u_align (
      .i_data     (dat_i),
      .i_off      (r_off),
      .i_size     (r_size),
      .i_unsigned (r_uns),
      .o_data     (w_load)
   );

   assign busy      = (r_state == ST_BUS);
   assign req_ready = rst && (r_state != ST_BUS);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state        <= ST_IDLE;
         r_off          <= '0;
         r_size         <= '0;
         r_uns          <= 1'b0;
         r_lwe          <= 1'b0;
         r_cnt          <= '0;
         cyc_o          <= 1'b0;
         stb_o          <= 1'b0;
         we_o           <= 1'b0;
         sel_o          <= '0;
         adr_o          <= '0;
         dat_o          <= '0;
         rsp_valid      <= 1'b0;
         rsp_rdata      <= '0;
         rsp_err        <= 1'b0;
         rsp_misaligned <= 1'b0;
         rsp_timeout    <= 1'b0;
      end else begin
         // Response fields are a single-cycle pulse; set only on entry to RESP.
         rsp_valid      <= 1'b0;
         rsp_rdata      <= '0;
         rsp_err        <= 1'b0;
         rsp_misaligned <= 1'b0;
         rsp_timeout    <= 1'b0;
         case (r_state)
            ST_IDLE, ST_RESP: begin
               r_state <= ST_IDLE;
               if (req_valid) begin
                  r_off  <= w_off;
                  r_size <= req_size;
                  r_uns  <= req_unsigned;
                  r_lwe  <= req_we;
                  if (w_mis) begin
                     r_state        <= ST_RESP;
                     rsp_valid      <= 1'b1;
                     rsp_misaligned <= 1'b1;
                  end else begin
                     r_state <= ST_BUS;
                     r_cnt   <= '0;
                     cyc_o   <= 1'b1;
                     stb_o   <= 1'b1;
                     we_o    <= req_we;
                     sel_o   <= w_sel;
                     adr_o   <= {req_addr[AW-1:OW], {OW{1'b0}}};
                     dat_o   <= w_dat;
                  end
               end
            end
            ST_BUS: begin
               r_cnt <= r_cnt + TW'(1);
               if (ack_i || err_i) begin
                  r_state   <= ST_RESP;
                  cyc_o     <= 1'b0;
                  stb_o     <= 1'b0;
                  we_o      <= 1'b0;
                  sel_o     <= '0;
                  rsp_valid <= 1'b1;
                  if (err_i)
                     rsp_err <= 1'b1;
                  else if (!r_lwe)
                     rsp_rdata <= w_load;
               end else if (TIMEOUT != 0 && r_cnt == TO_LAST) begin
                  r_state     <= ST_RESP;
                  cyc_o       <= 1'b0;
                  stb_o       <= 1'b0;
                  we_o        <= 1'b0;
                  sel_o       <= '0;
                  rsp_valid   <= 1'b1;
                  rsp_timeout <= 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/wb_data_port_lsu.md
Name: wb_data_port_lsu

Overview:
- Parametrised successor of the core's load/store data port.
- Accepts one load/store request at a time from the memory stage over a valid/ready handshake and runs a single Wishbone classic cycle.
- Generalised in data width (32/64), access size (byte/half/word/dword) and byte-lane steering by address offset.
- Adds misalignment trapping, a bus timeout and a registered response channel with sign/zero extension.
- Sits between the execute/memory stage and the data-memory Wishbone bus.

Parameters:
- AW, 32, address width.
- DW, 32, data width; legal values 32 or 64.
- TIMEOUT, 64, maximum cycles waiting for ack/err before abort; 0 disables the timeout.
- TW, 7, timeout counter width; TW >= clog2(TIMEOUT+1).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-low (asserted when 0)
- req_valid  in  1  request present
- req_ready  out  1  LSU can accept a request
- req_we  in  1  1=store, 0=load
- req_size  in  2  0=byte 1=half 2=word 3=dword
- req_unsigned  in  1  zero-extend load result
- req_addr  in  AW  byte address
- req_wdata  in  DW  store data, right-justified
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  DW  extended load data; 0 for stores and faults
- rsp_err  out  1  bus error (err_i)
- rsp_misaligned  out  1  misaligned or illegal size; no bus cycle issued
- rsp_timeout  out  1  bus timeout
- busy  out  1  request in flight; use as mem_stall
- dat_i  in  DW  Wishbone read data
- ack_i  in  1  Wishbone acknowledge
- err_i  in  1  Wishbone error
- adr_o  out  AW  Wishbone address, aligned to DW/8
- dat_o  out  DW  Wishbone write data, lane-replicated
- sel_o  out  DW/8  byte-lane select
- cyc_o  out  1  Wishbone cycle
- stb_o  out  1  Wishbone strobe
- we_o  out  1  Wishbone write enable

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - Outputs cyc_o, stb_o, we_o, sel_o, adr_o, dat_o, rsp_* and busy are 0.
  - req_ready is 1 once rst deasserts.
- FSM states IDLE, BUS, RESP.
- IDLE:
  - req_ready=1, busy=0.
  - Request accepted on req_valid&req_ready at edge T.
  - Legality check: half needs addr[0]==0; word needs addr[1:0]==0; dword needs addr[2:0]==0 and DW==64. Size 3 with DW==32 is illegal.
  - Illegal request -> RESP with rsp_misaligned=1; cyc_o stays 0.
  - Legal request -> BUS with registered outputs driven from T+1:
    - cyc_o=stb_o=1, we_o=req_we.
    - adr_o = addr with low clog2(DW/8) bits cleared.
    - sel_o = size mask (1, 3, F, FF) shifted left by the byte offset.
    - dat_o = req_wdata low bytes replicated across all lanes.
- Request latch: offset, size, unsigned and we are latched at acceptance. The requester may change req_* after T.
- BUS:
  - busy=1, req_ready=0.
  - Timeout counter clears on entry and increments each BUS cycle.
  - On ack_i or err_i: cyc_o/stb_o/we_o/sel_o drop at the next edge, then RESP.
  - Load data is captured from dat_i on the ack cycle.
  - err_i and ack_i together: error wins, rsp_err=1.
  - TIMEOUT!=0 and counter reaches TIMEOUT-1 with no ack/err: abort, drop cyc/stb, RESP with rsp_timeout=1.
  - A late ack after abort is ignored.
- RESP:
  - rsp_valid=1 for exactly one cycle, then IDLE.
  - req_ready=1 in RESP, so back-to-back requests are accepted there.
  - Exactly one of err/misaligned/timeout is set on a fault; none on success.
- Load extraction: shift captured data right by offset*8, then mask to size. Sign-extend from bit 7/15/31 unless req_unsigned. A dword load with DW==64 passes through unchanged.
- Latency:
  - Legal access acked k cycles after cyc_o rises (k>=0 means ack in first BUS cycle): rsp_valid at T+2+k.
  - Misaligned access: rsp_valid at T+1.
- Reset mid-operation: cyc_o/stb_o drop immediately (asynchronous) and no response is issued.
- Outputs do not depend combinationally on ack_i or err_i. busy and req_ready are decoded from state.

Decomposition:
- Package lsu_pkg holds:
  - size encodings SZ_B/SZ_H/SZ_W/SZ_D;
  - state encoding;
  - function size_mask(size) returning the byte mask;
  - function misaligned(size, addr, DW).
- Sub-module lsu_load_align (combinational): inputs raw data, offset, size, unsigned; output extended data. Implement it once, reuse it for the instruction side later.

Test Plan:
- DW=32, load word addr 0x100; slave acks with 0x8000_00F0 after 2 wait cycles -> sel_o=F, adr_o=0x100; rsp_valid at T+4; rsp_rdata=0x8000_00F0, no flags.
- DW=32, signed byte load addr 0x103, dat_i=0x85_00_00_00 -> sel_o=8, rsp_rdata=0xFFFF_FF85; same access with req_unsigned=1 -> 0x0000_0085.
- DW=64, store half 0xBEEF at addr 0x206 -> adr_o=0x200, sel_o=0xC0, dat_o lanes 7:6=0xBEEF, we_o=1; rsp_rdata=0.
- Load word addr 0x102 -> cyc_o never asserted; rsp_valid at T+1 with rsp_misaligned=1. Repeat with DW=32, size 3 -> same result.
- TIMEOUT=8, slave never responds -> cyc_o high 8 cycles then drops, rsp_timeout=1. Next request accepted in the RESP cycle. Separately: ack_i and err_i together -> rsp_err=1.
- Assert rst=0 while in BUS -> cyc_o/stb_o low before the next edge; no rsp_valid; req_ready=1 after release.
